// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point unit: divider state encoding,
// default operand format and saturation bounds.
package fixed_point_pkg;

    localparam int FP_WIDTH = 32;
    localparam int FP_FBITS = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIX    = 2'd2
    } div_state_e;

    // Largest positive two's-complement value of a w-bit word (w <= 64).
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative w-bit value, also its magnitude.
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_point_divider_if.sv
// Start/ready issue port of the fixed-point divider.
interface fixed_point_divider_if #(
    parameter int WIDTH = fixed_point_pkg::FP_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic             busy;
    logic             ready;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, busy, ready, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, busy, ready, div_by_zero, overflow
    );
endinterface

// File: rtl/fixed_point_div_step.sv
// One restoring-division iteration: shift in the next numerator bit,
// subtract the divisor when it fits.
module fixed_point_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] den_i,
    output logic [WIDTH:0]   rem_o,
    output logic             qbit_o
);
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] den_ext;

    assign shifted = {rem_i, bit_i};
    assign den_ext = {2'b00, den_i};
    assign qbit_o  = (shifted >= den_ext);
    // The remainder stays below the divisor, so the top bit always drops out.
    assign rem_o   = (WIDTH+1)'(qbit_o ? (shifted - den_ext) : shifted);
endmodule

// File: rtl/fixed_point_divider.sv
// Iterative signed Q(WIDTH-FBITS).FBITS divider, one quotient bit per clock,
// saturating on overflow and divide-by-zero.
module fixed_point_divider
    import fixed_point_pkg::*;
#(
    parameter int WIDTH = FP_WIDTH,
    parameter int FBITS = FP_FBITS
) (
    input  logic clk,
    input  logic reset,
    fixed_point_divider_if.slave bus
);
    localparam int NW = WIDTH + FBITS;
    localparam int CW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [63:0]      MAX64   = sat_max(WIDTH);
    localparam logic [63:0]      MIN64   = sat_min(WIDTH);
    localparam logic [WIDTH-1:0] SAT_MAX = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SAT_MIN = MIN64[WIDTH-1:0];
    localparam logic [NW-1:0]    LIM_POS = NW'(SAT_MAX);
    localparam logic [NW-1:0]    LIM_NEG = NW'(SAT_MIN);

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [NW-1:0]    num_q, num_d;
    logic [NW-1:0]    qmag_q, qmag_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             sign_q, sign_d;
    logic             neg_dvd_q, neg_dvd_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;
    logic             dbz_q, dbz_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] abs_dividend;
    logic [WIDTH-1:0] abs_divisor;
    logic [WIDTH:0]   step_rem;
    logic             step_qbit;

    // Unsigned magnitudes; the most negative value maps onto 2^(WIDTH-1) exactly.
    assign abs_dividend = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign abs_divisor  = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;

    fixed_point_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i  (rem_q),
        .bit_i  (num_q[NW-1]),
        .den_i  (den_q),
        .rem_o  (step_rem),
        .qbit_o (step_qbit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            num_q      <= '0;
            qmag_q     <= '0;
            den_q      <= '0;
            sign_q     <= 1'b0;
            neg_dvd_q  <= 1'b0;
            quotient_q <= '0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            num_q      <= num_d;
            qmag_q     <= qmag_d;
            den_q      <= den_d;
            sign_q     <= sign_d;
            neg_dvd_q  <= neg_dvd_d;
            quotient_q <= quotient_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        num_d      = num_q;
        qmag_d     = qmag_q;
        den_d      = den_q;
        sign_d     = sign_q;
        neg_dvd_d  = neg_dvd_q;
        quotient_d = quotient_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sign_d    = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    neg_dvd_d = bus.dividend[WIDTH-1];
                    num_d     = NW'(abs_dividend) << FBITS;
                    den_d     = abs_divisor;
                    rem_d     = '0;
                    cnt_d     = '0;
                    qmag_d    = '0;
                    busy_d    = 1'b1;
                    ovf_d     = 1'b0;
                    dbz_d     = (bus.divisor == '0);
                    state_d   = (bus.divisor == '0) ? FIX : DIVIDE;
                end
            end
            DIVIDE: begin
                num_d  = num_q << 1;
                rem_d  = step_rem;
                qmag_d = {qmag_q[NW-2:0], step_qbit};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(NW - 1)) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
                if (dbz_q) begin
                    quotient_d = neg_dvd_q ? SAT_MIN : SAT_MAX;
                end else if (!sign_q && (qmag_q > LIM_POS)) begin
                    quotient_d = SAT_MAX;
                    ovf_d      = 1'b1;
                end else if (sign_q && (qmag_q > LIM_NEG)) begin
                    quotient_d = SAT_MIN;
                    ovf_d      = 1'b1;
                end else begin
                    // Negating a zero magnitude yields 0, so no negative zero appears.
                    quotient_d = sign_q ? -qmag_q[WIDTH-1:0] : qmag_q[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.quotient    = quotient_q;
    assign bus.busy        = busy_q;
    assign bus.ready       = ready_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_fixed_point_divider.sv
// Self-checking bench for fixed_point_divider: directed corner cases plus
// random operands against a 64-bit integer-arithmetic reference.
module tb_fixed_point_divider;
    import fixed_point_pkg::*;

    localparam int W = 32;
    localparam int F = 10;
    localparam int LAT = W + F + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fixed_point_divider_if #(.WIDTH(W)) bus ();

    fixed_point_divider #(.WIDTH(W), .FBITS(F)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: exact rational result truncated toward zero, then saturated.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic dz, output logic ov);
        longint sa, sb, qq, maxv, minv;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxv = (longint'(1) <<< (W - 1)) - 1;
        minv = -(longint'(1) <<< (W - 1));
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            dz = 1'b1;
            q  = (sa < 0) ? W'(minv) : W'(maxv);
        end else begin
            qq = (sa * (longint'(1) <<< F)) / sb;
            if (qq > maxv) begin
                ov = 1'b1;
                qq = maxv;
            end else if (qq < minv) begin
                ov = 1'b1;
                qq = minv;
            end
            q = W'(qq);
        end
    endfunction

    // Issue one division and wait (bounded) for ready; lat = -1 on timeout.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] q, output logic dz, output logic ov,
                          output int lat, output bit busy_ok, output logic busy_at_ready);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        busy_ok   = (bus.busy === 1'b1);
        lat       = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
        end
        q             = bus.quotient;
        dz            = bus.div_by_zero;
        ov            = bus.overflow;
        busy_at_ready = bus.busy;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.quotient, bus.busy, bus.ready, bus.div_by_zero, bus.overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got q=%h busy=%b ready=%b dz=%b ov=%b required all zero",
                     bus.quotient, bus.busy, bus.ready, bus.div_by_zero, bus.overflow);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got busy=%b ready=%b required 0/0", bus.busy, bus.ready);
        end
        $display("reset: q=%h busy=%b ready=%b", bus.quotient, bus.busy, bus.ready);
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [12];
        logic [W-1:0] tb [12];
        logic [W-1:0] tq [12];
        logic         tdz [12];
        logic         tov [12];
        logic [W-1:0] q;
        logic         dz, ov, busy_r;
        int           lat, exp_lat;
        bit           busy_ok;
        ta  = '{32'h00000C00, 32'hFFFFE200, 32'h00000400, 32'h00001400, 32'hFFFFEC00, 32'h7FFFFFFF,
                32'h80000000, 32'h80000000, 32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFD};
        tb  = '{32'h00000800, 32'h00000A00, 32'h00000C00, 32'h00000000, 32'h00000000, 32'h00000001,
                32'hFFFFFC00, 32'h00000400, 32'hFFFFFC00, 32'h00000C00, 32'h7FFFFFFF, 32'h00000002};
        tq  = '{32'h00000600, 32'hFFFFF400, 32'h00000155, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF,
                32'h7FFFFFFF, 32'h80000000, 32'h00000000, 32'h00000000, 32'h00000400, 32'hFFFFFA00};
        tdz = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tov = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 12; i++) begin
            do_div(ta[i], tb[i], q, dz, ov, lat, busy_ok, busy_r);
            exp_lat = tdz[i] ? 1 : LAT;
            $display("directed %0d: %h / %h -> q=%h dz=%b ov=%b lat=%0d", i, ta[i], tb[i], q, dz, ov, lat);
            vectors++;
            if (q !== tq[i] || dz !== tdz[i] || ov !== tov[i]) begin
                miscompares++;
                $display("FAIL directed_result[%0d]: got q=%h dz=%b ov=%b required q=%h dz=%b ov=%b",
                         i, q, dz, ov, tq[i], tdz[i], tov[i]);
            end
            vectors++;
            if (lat != exp_lat) begin
                miscompares++;
                $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, exp_lat);
            end
            vectors++;
            if (!busy_ok || busy_r !== 1'b0) begin
                miscompares++;
                $display("FAIL directed_busy[%0d]: got busy_during_ok=%b busy_at_ready=%b required 1/0",
                         i, busy_ok, busy_r);
            end
            @(posedge clk);
            #1;
            vectors++;
            if (bus.ready !== 1'b0 || bus.quotient !== tq[i]) begin
                miscompares++;
                $display("FAIL directed_pulse[%0d]: got ready=%b q=%h required ready=0 q=%h",
                         i, bus.ready, bus.quotient, tq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, eq;
        logic [W-1:0] edges [7];
        logic         dz, ov, edz, eov, busy_r;
        int           lat, exp_lat;
        bit           busy_ok;
        edges = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000,
                  32'h7FFFFFFF, 32'h00000400, 32'hFFFFFC00};
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: ;
                1: begin
                    a = {{12{a[19]}}, a[19:0]};
                    b = {{16{b[15]}}, b[15:0]};
                end
                2: b = ($urandom_range(0, 1) == 0) ? '0 : {{20{b[11]}}, b[11:0]};
                default: begin
                    a = edges[$urandom_range(0, 6)];
                    b = edges[$urandom_range(0, 6)];
                end
            endcase
            ref_div(a, b, eq, edz, eov);
            do_div(a, b, q, dz, ov, lat, busy_ok, busy_r);
            exp_lat = edz ? 1 : LAT;
            $display("random %0d: %h / %h -> q=%h dz=%b ov=%b lat=%0d", i, a, b, q, dz, ov, lat);
            vectors++;
            if (q !== eq || dz !== edz || ov !== eov || lat != exp_lat) begin
                miscompares++;
                $display("FAIL random[%0d]: got q=%h dz=%b ov=%b lat=%0d required q=%h dz=%b ov=%b lat=%0d",
                         i, q, dz, ov, lat, eq, edz, eov, exp_lat);
            end
        end
    endtask

    task automatic test_ignored_start();
        int  lat = -1;
        int  extra = 0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'h00000C00;
        bus.divisor  = 32'h00000800;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int n = 1; n <= 200; n++) begin
            if (n >= 10 && n < 13) begin
                bus.start    = 1'b1;
                bus.dividend = 32'hFFFFE200;
                bus.divisor  = 32'h00000A00;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.ready === 1'b1) begin
                lat = n;
                break;
            end
        end
        bus.start = 1'b0;
        $display("ignored_start: q=%h lat=%0d", bus.quotient, lat);
        vectors++;
        if (bus.quotient !== 32'h00000600 || lat != LAT) begin
            miscompares++;
            $display("FAIL ignored_start: got q=%h lat=%0d required q=00000600 lat=%0d",
                     bus.quotient, lat, LAT);
        end
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready === 1'b1) extra++;
        end
        vectors++;
        if (extra != 0) begin
            miscompares++;
            $display("FAIL ignored_start_no_second: got %0d extra ready pulses required 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int           r1 = -1;
        int           r2 = -1;
        logic [W-1:0] q1 = '0;
        logic [W-1:0] q2 = '0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'h00000400;
        bus.divisor  = 32'h00000C00;
        @(posedge clk);
        #1;
        bus.dividend = 32'hFFFFE200;
        bus.divisor  = 32'h00000A00;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready === 1'b1) begin
                if (r1 < 0) begin
                    r1 = n;
                    q1 = bus.quotient;
                end else begin
                    r2 = n;
                    q2 = bus.quotient;
                    break;
                end
            end
        end
        bus.start = 1'b0;
        $display("back_to_back: q1=%h at %0d, q2=%h at %0d", q1, r1, q2, r2);
        vectors++;
        if (q1 !== 32'h00000155 || r1 != LAT) begin
            miscompares++;
            $display("FAIL b2b_first: got q=%h at %0d required 00000155 at %0d", q1, r1, LAT);
        end
        vectors++;
        if (q2 !== 32'hFFFFF400 || r2 != 2 * LAT + 1) begin
            miscompares++;
            $display("FAIL b2b_second: got q=%h at %0d required FFFFF400 at %0d", q2, r2, 2 * LAT + 1);
        end
        repeat (50) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        int           pulses = 0;
        logic [W-1:0] q;
        logic         dz, ov, busy_r;
        int           lat;
        bit           busy_ok;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'h00000C00;
        bus.divisor  = 32'h00000800;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("reset_abort: q=%h busy=%b ready=%b dz=%b ov=%b",
                 bus.quotient, bus.busy, bus.ready, bus.div_by_zero, bus.overflow);
        vectors++;
        if ({bus.quotient, bus.busy, bus.ready, bus.div_by_zero, bus.overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_abort_outputs: got q=%h busy=%b ready=%b dz=%b ov=%b required all zero",
                     bus.quotient, bus.busy, bus.ready, bus.div_by_zero, bus.overflow);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk);
            #1;
            if (bus.ready === 1'b1 || bus.busy === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 0) begin
            miscompares++;
            $display("FAIL reset_abort_quiet: got %0d busy/ready cycles required 0", pulses);
        end
        do_div(32'h00000400, 32'h00000C00, q, dz, ov, lat, busy_ok, busy_r);
        $display("after_abort: q=%h lat=%0d", q, lat);
        vectors++;
        if (q !== 32'h00000155 || dz !== 1'b0 || ov !== 1'b0 || lat != LAT) begin
            miscompares++;
            $display("FAIL after_abort: got q=%h dz=%b ov=%b lat=%0d required 00000155/0/0/%0d",
                     q, dz, ov, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
